// File: rtl/uart_port_if.sv
// ---------------------------------------------------------------------------
// uart_port_if
// CPU-side handshake and status bundle for uart_port.
//   rdn        : active-low read strobe (controller -> port)
//   wrn        : active-low write strobe (controller -> port)
//   data_ready : receive holding register holds an unread byte
//   tbre       : transmit holding register empty
//   tsre       : transmit shift register idle
//   rx_err     : one-cycle pulse on a receive framing error
// The 8-bit data bus itself is a plain inout port on uart_port so that the
// tri-state driver stays on a module boundary.
// ---------------------------------------------------------------------------
interface uart_port_if;
    logic rdn;
    logic wrn;
    logic data_ready;
    logic tbre;
    logic tsre;
    logic rx_err;

    modport master (
        output rdn,
        output wrn,
        input  data_ready,
        input  tbre,
        input  tsre,
        input  rx_err
    );

    modport slave (
        input  rdn,
        input  wrn,
        output data_ready,
        output tbre,
        output tsre,
        output rx_err
    );
endinterface

// File: rtl/uart_port.sv
// ---------------------------------------------------------------------------
// uart_port
// Byte-wide UART with one transmit holding register, one transmit shifter
// and one receive holding register. 8 data bits, no parity, 1 stop bit.
// Ports:
//   clk_50MHz : system clock, all logic on the rising edge
//   rst       : synchronous active-low reset
//   data      : 8-bit CPU data bus; driven with rx_hold while rdn is low
//   bus       : uart_port_if.slave (rdn, wrn, data_ready, tbre, tsre, rx_err)
//   txd       : serial transmit line, idles high
//   rxd       : serial receive line, asynchronous to clk_50MHz
// Parameter:
//   CLKS_PER_BIT : clock cycles per serial bit, must be >= 4
// ---------------------------------------------------------------------------
module uart_port #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk_50MHz,
    input  logic       rst,
    inout  wire  [7:0] data,
    uart_port_if.slave bus,
    output logic       txd,
    input  logic       rxd
);

    localparam int              CW       = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]   CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
    localparam logic [CW-1:0]   CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]   CNT_HALF = CW'(CLKS_PER_BIT / 2);

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    // Strobe history and rising-edge completions
    logic rdn_q_r;
    logic wrn_q_r;
    logic rd_done_s;
    logic wr_done_s;

    // Receive line synchronizer plus one extra stage for edge detection
    logic sync1_r;
    logic sync2_r;
    logic rx_prev_r;

    // Transmit path
    tx_state_t   tx_state_r, tx_state_s;
    logic [CW-1:0] tx_cnt_r, tx_cnt_s;
    logic [2:0]  tx_bit_r, tx_bit_s;
    logic [7:0]  tx_shift_r, tx_shift_s;
    logic [7:0]  tx_hold_r, tx_hold_s;
    logic        txd_r, txd_s;
    logic        tbre_r, tbre_s;
    logic        tsre_r, tsre_s;
    logic        tx_last_s;

    // Receive path
    rx_state_t   rx_state_r, rx_state_s;
    logic [CW-1:0] rx_cnt_r, rx_cnt_s;
    logic [2:0]  rx_bit_r, rx_bit_s;
    logic [7:0]  rx_shift_r, rx_shift_s;
    logic [7:0]  rx_hold_r, rx_hold_s;
    logic        data_ready_r, data_ready_s;
    logic        rx_err_r, rx_err_s;
    logic        rx_last_s;

    // Register the strobes so a completed access is seen at its rising edge
    always_ff @(posedge clk_50MHz) begin
        if (!rst) begin
            rdn_q_r <= 1'b1;
            wrn_q_r <= 1'b1;
        end else begin
            rdn_q_r <= bus.rdn;
            wrn_q_r <= bus.wrn;
        end
    end

    assign rd_done_s = !rdn_q_r && bus.rdn;
    assign wr_done_s = !wrn_q_r && bus.wrn;

    // Two-flop synchronizer for rxd plus the previous synchronized level
    always_ff @(posedge clk_50MHz) begin
        if (!rst) begin
            sync1_r   <= 1'b1;
            sync2_r   <= 1'b1;
            rx_prev_r <= 1'b1;
        end else begin
            sync1_r   <= rxd;
            sync2_r   <= sync1_r;
            rx_prev_r <= sync2_r;
        end
    end

    // TX next-state: CPU write into the holding register and the bit FSM.
    // A write is taken only while tbre=1 and the FSM loads only while
    // tbre=0, so the two never touch tbre on the same edge.
    always_comb begin
        tx_state_s = tx_state_r;
        tx_cnt_s   = tx_cnt_r;
        tx_bit_s   = tx_bit_r;
        tx_shift_s = tx_shift_r;
        tx_hold_s  = tx_hold_r;
        txd_s      = txd_r;
        tbre_s     = tbre_r;
        tsre_s     = tsre_r;
        tx_last_s  = (tx_cnt_r == CNT_LAST);

        if (wr_done_s && tbre_r) begin
            tx_hold_s = data;
            tbre_s    = 1'b0;
        end else begin
            tx_hold_s = tx_hold_r;
        end

        case (tx_state_r)
            TX_IDLE: begin
                tx_cnt_s = CNT_ZERO;
                if (!tbre_r) begin
                    tx_shift_s = tx_hold_r;
                    tx_bit_s   = 3'd0;
                    tbre_s     = 1'b1;
                    tsre_s     = 1'b0;
                    txd_s      = 1'b0;
                    tx_state_s = TX_START;
                end else begin
                    txd_s = 1'b1;
                end
            end
            TX_START: begin
                if (tx_last_s) begin
                    tx_cnt_s   = CNT_ZERO;
                    txd_s      = tx_shift_r[0];
                    tx_state_s = TX_DATA;
                end else begin
                    tx_cnt_s = tx_cnt_r + CNT_ONE;
                end
            end
            TX_DATA: begin
                if (tx_last_s) begin
                    tx_cnt_s = CNT_ZERO;
                    if (tx_bit_r == 3'd7) begin
                        txd_s      = 1'b1;
                        tx_state_s = TX_STOP;
                    end else begin
                        // shift_r[0] is the bit on the line; [1] is next
                        tx_bit_s   = tx_bit_r + 3'd1;
                        tx_shift_s = {1'b0, tx_shift_r[7:1]};
                        txd_s      = tx_shift_r[1];
                    end
                end else begin
                    tx_cnt_s = tx_cnt_r + CNT_ONE;
                end
            end
            TX_STOP: begin
                if (tx_last_s) begin
                    tx_cnt_s = CNT_ZERO;
                    if (!tbre_r) begin
                        // Next byte already waiting: start it with no gap
                        tx_shift_s = tx_hold_r;
                        tx_bit_s   = 3'd0;
                        tbre_s     = 1'b1;
                        txd_s      = 1'b0;
                        tx_state_s = TX_START;
                    end else begin
                        tsre_s     = 1'b1;
                        tx_state_s = TX_IDLE;
                    end
                end else begin
                    tx_cnt_s = tx_cnt_r + CNT_ONE;
                end
            end
            default: begin
                tx_cnt_s   = CNT_ZERO;
                txd_s      = 1'b1;
                tx_state_s = TX_IDLE;
            end
        endcase
    end

    // TX state and datapath registers
    always_ff @(posedge clk_50MHz) begin
        if (!rst) begin
            tx_state_r <= TX_IDLE;
            tx_cnt_r   <= CNT_ZERO;
            tx_bit_r   <= 3'd0;
            tx_shift_r <= 8'h00;
            tx_hold_r  <= 8'h00;
            txd_r      <= 1'b1;
            tbre_r     <= 1'b1;
            tsre_r     <= 1'b1;
        end else begin
            tx_state_r <= tx_state_s;
            tx_cnt_r   <= tx_cnt_s;
            tx_bit_r   <= tx_bit_s;
            tx_shift_r <= tx_shift_s;
            tx_hold_r  <= tx_hold_s;
            txd_r      <= txd_s;
            tbre_r     <= tbre_s;
            tsre_r     <= tsre_s;
        end
    end

    // RX next-state: mid-bit sampling FSM and the receive holding register.
    // A completed read clears data_ready, but a frame completing on the
    // same edge is assigned later and therefore wins.
    always_comb begin
        rx_state_s   = rx_state_r;
        rx_cnt_s     = rx_cnt_r;
        rx_bit_s     = rx_bit_r;
        rx_shift_s   = rx_shift_r;
        rx_hold_s    = rx_hold_r;
        data_ready_s = data_ready_r;
        rx_err_s     = 1'b0;
        rx_last_s    = (rx_cnt_r == CNT_LAST);

        if (rd_done_s) begin
            data_ready_s = 1'b0;
        end else begin
            data_ready_s = data_ready_r;
        end

        case (rx_state_r)
            RX_IDLE: begin
                rx_cnt_s = CNT_ZERO;
                rx_bit_s = 3'd0;
                if (rx_prev_r && !sync2_r) begin
                    rx_state_s = RX_START;
                end else begin
                    rx_state_s = RX_IDLE;
                end
            end
            RX_START: begin
                if (rx_cnt_r == CNT_HALF) begin
                    // From here every CLKS_PER_BIT cycles lands on mid-bit
                    rx_cnt_s = CNT_ZERO;
                    if (sync2_r) begin
                        rx_state_s = RX_IDLE;
                    end else begin
                        rx_bit_s   = 3'd0;
                        rx_state_s = RX_DATA;
                    end
                end else begin
                    rx_cnt_s = rx_cnt_r + CNT_ONE;
                end
            end
            RX_DATA: begin
                if (rx_last_s) begin
                    rx_cnt_s   = CNT_ZERO;
                    rx_shift_s = {sync2_r, rx_shift_r[7:1]};
                    if (rx_bit_r == 3'd7) begin
                        rx_state_s = RX_STOP;
                    end else begin
                        rx_bit_s = rx_bit_r + 3'd1;
                    end
                end else begin
                    rx_cnt_s = rx_cnt_r + CNT_ONE;
                end
            end
            RX_STOP: begin
                if (rx_last_s) begin
                    rx_cnt_s   = CNT_ZERO;
                    rx_state_s = RX_IDLE;
                    if (sync2_r) begin
                        rx_hold_s    = rx_shift_r;
                        data_ready_s = 1'b1;
                    end else begin
                        rx_err_s = 1'b1;
                    end
                end else begin
                    rx_cnt_s = rx_cnt_r + CNT_ONE;
                end
            end
            default: begin
                rx_cnt_s   = CNT_ZERO;
                rx_state_s = RX_IDLE;
            end
        endcase
    end

    // RX state and datapath registers
    always_ff @(posedge clk_50MHz) begin
        if (!rst) begin
            rx_state_r   <= RX_IDLE;
            rx_cnt_r     <= CNT_ZERO;
            rx_bit_r     <= 3'd0;
            rx_shift_r   <= 8'h00;
            rx_hold_r    <= 8'h00;
            data_ready_r <= 1'b0;
            rx_err_r     <= 1'b0;
        end else begin
            rx_state_r   <= rx_state_s;
            rx_cnt_r     <= rx_cnt_s;
            rx_bit_r     <= rx_bit_s;
            rx_shift_r   <= rx_shift_s;
            rx_hold_r    <= rx_hold_s;
            data_ready_r <= data_ready_s;
            rx_err_r     <= rx_err_s;
        end
    end

    assign data           = (!bus.rdn) ? rx_hold_r : 8'bzzzz_zzzz;
    assign txd            = txd_r;
    assign bus.tbre       = tbre_r;
    assign bus.tsre       = tsre_r;
    assign bus.data_ready = data_ready_r;
    assign bus.rx_err     = rx_err_r;

endmodule

// File: tb/tb_uart_port.sv
module tb_uart_port;

    localparam int C = 16;

    logic       clk_50MHz = 1'b0;
    logic       rst;
    logic       rxd;
    logic       txd;
    wire  [7:0] data;
    logic [7:0] drv_val;
    logic       drv_en;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int err_cnt = 0;

    // Reference model of the receive side: what the holding register and
    // data_ready flag should show from the CPU's point of view.
    logic [7:0] exp_hold;
    logic       exp_dr;

    uart_port_if bus ();

    assign data = drv_en ? drv_val : 8'bzzzz_zzzz;

    uart_port #(.CLKS_PER_BIT(C)) dut (
        .clk_50MHz (clk_50MHz),
        .rst       (rst),
        .data      (data),
        .bus       (bus.slave),
        .txd       (txd),
        .rxd       (rxd)
    );

    always #10 clk_50MHz = ~clk_50MHz;

    always @(posedge clk_50MHz) cyc <= cyc + 1;

    always @(negedge clk_50MHz) begin
        if (bus.rx_err === 1'b1) err_cnt <= err_cnt + 1;
    end

    initial begin
        #4000000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk_50MHz);
        #1;
    endtask

    task automatic cpu_write(input logic [7:0] v);
        drv_val = v; drv_en = 1'b1; bus.wrn = 1'b0;
        tick(1);
        bus.wrn = 1'b1;
        tick(1);
        drv_en = 1'b0;
    endtask

    task automatic cpu_read(output logic [7:0] v);
        bus.rdn = 1'b0;
        @(negedge clk_50MHz);
        v = data;
        tick(2);
        bus.rdn = 1'b1;
    endtask

    // Start bit plus eight data bits, LSB first; caller drives the stop bit.
    task automatic rx_bits(input logic [7:0] v);
        rxd = 1'b0;
        tick(C);
        for (int i = 0; i < 8; i++) begin
            rxd = v[i];
            tick(C);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; rxd = 1'b1; bus.rdn = 1'b1; bus.wrn = 1'b1;
        drv_en = 1'b0; drv_val = 8'h00;
        tick(2);
        rst = 1'b1;
        @(negedge clk_50MHz);
        total++; if (txd !== 1'b1) begin bad++; $display("FAIL reset_txd: got %b want 1", txd); end
        total++; if (bus.tbre !== 1'b1) begin bad++; $display("FAIL reset_tbre: got %b want 1", bus.tbre); end
        total++; if (bus.tsre !== 1'b1) begin bad++; $display("FAIL reset_tsre: got %b want 1", bus.tsre); end
        total++; if (bus.data_ready !== 1'b0) begin bad++; $display("FAIL reset_data_ready: got %b want 0", bus.data_ready); end
        total++; if (bus.rx_err !== 1'b0) begin bad++; $display("FAIL reset_rx_err: got %b want 0", bus.rx_err); end
        exp_hold = 8'h00; exp_dr = 1'b0;
        tick(1);
    endtask

    task automatic test_tx_single(input logic [7:0] v);
        logic [9:0] exp_frame;
        logic [9:0] cap;
        int t0;
        int n;
        exp_frame = {1'b1, v, 1'b0};
        drv_val = v; drv_en = 1'b1; bus.wrn = 1'b0;
        tick(1);
        bus.wrn = 1'b1;
        tick(1);
        drv_en = 1'b0;
        @(negedge clk_50MHz);
        total++; if (bus.tbre !== 1'b0) begin bad++; $display("FAIL tx_tbre_clear %h: got %b want 0", v, bus.tbre); end
        @(negedge clk_50MHz);
        total++; if (bus.tbre !== 1'b1) begin bad++; $display("FAIL tx_tbre_set %h: got %b want 1", v, bus.tbre); end
        total++; if (txd !== 1'b0) begin bad++; $display("FAIL tx_start_edge %h: got %b want 0", v, txd); end
        t0 = cyc;
        repeat (8) @(negedge clk_50MHz);
        for (int i = 0; i < 10; i++) begin
            cap[i] = txd;
            if (i < 9) repeat (C) @(negedge clk_50MHz);
        end
        total++; if (cap !== exp_frame) begin bad++; $display("FAIL tx_frame %h: got %b want %b", v, cap, exp_frame); end
        n = 0;
        while (bus.tsre !== 1'b1 && n < 100) begin
            @(negedge clk_50MHz);
            n++;
        end
        total++; if (cyc - t0 !== 10 * C) begin bad++; $display("FAIL tx_tsre_time %h: got %0d want %0d", v, cyc - t0, 10 * C); end
        total++; if (txd !== 1'b1) begin bad++; $display("FAIL tx_idle_line %h: got %b want 1", v, txd); end
        tick(3);
    endtask

    task automatic test_back_to_back(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        logic [19:0] exp_frames;
        logic [19:0] cap;
        logic        stayed_high;
        int t0;
        int n;
        exp_frames = {1'b1, b, 1'b0, 1'b1, a, 1'b0};
        cpu_write(a);
        n = 0;
        @(negedge clk_50MHz);
        while (txd !== 1'b0 && n < 10) begin
            @(negedge clk_50MHz);
            n++;
        end
        total++; if (txd !== 1'b0) begin bad++; $display("FAIL b2b_first_start: got %b want 0", txd); end
        t0 = cyc;
        fork
            begin
                repeat (8) @(negedge clk_50MHz);
                for (int i = 0; i < 20; i++) begin
                    cap[i] = txd;
                    if (i < 19) repeat (C) @(negedge clk_50MHz);
                end
            end
            begin
                tick(20);
                cpu_write(b);
                tick(10);
                total++; if (bus.tbre !== 1'b0) begin bad++; $display("FAIL b2b_tbre_full: got %b want 0", bus.tbre); end
                cpu_write(c);
            end
        join
        total++; if (cap !== exp_frames) begin bad++; $display("FAIL b2b_frames: got %b want %b", cap, exp_frames); end
        n = 0;
        while (bus.tsre !== 1'b1 && n < 100) begin
            @(negedge clk_50MHz);
            n++;
        end
        total++; if (cyc - t0 !== 20 * C) begin bad++; $display("FAIL b2b_tsre_time: got %0d want %0d", cyc - t0, 20 * C); end
        stayed_high = 1'b1;
        for (int i = 0; i < 12 * C; i++) begin
            @(negedge clk_50MHz);
            if (txd !== 1'b1) stayed_high = 1'b0;
        end
        total++; if (stayed_high !== 1'b1) begin bad++; $display("FAIL b2b_discard: got %b want 1", stayed_high); end
        total++; if (bus.tbre !== 1'b1) begin bad++; $display("FAIL b2b_tbre_end: got %b want 1", bus.tbre); end
        tick(2);
    endtask

    task automatic rx_good_frame(input logic [7:0] v, input string tag);
        rx_bits(v);
        rxd = 1'b1;
        @(negedge clk_50MHz);
        total++; if (bus.data_ready !== exp_dr) begin bad++; $display("FAIL %s_dr_before: got %b want %b", tag, bus.data_ready, exp_dr); end
        tick(C);
        exp_hold = v; exp_dr = 1'b1;
        @(negedge clk_50MHz);
        total++; if (bus.data_ready !== exp_dr) begin bad++; $display("FAIL %s_dr_after: got %b want %b", tag, bus.data_ready, exp_dr); end
        tick(1);
    endtask

    task automatic test_rx();
        logic [7:0] v;
        logic [7:0] got;
        rx_good_frame(8'h3C, "rx3c");
        cpu_read(got);
        total++; if (got !== exp_hold) begin bad++; $display("FAIL rx3c_read: got %h want %h", got, exp_hold); end
        exp_dr = 1'b0;
        tick(1);
        @(negedge clk_50MHz);
        total++; if (bus.data_ready !== exp_dr) begin bad++; $display("FAIL rx3c_dr_clear: got %b want %b", bus.data_ready, exp_dr); end
        drv_val = 8'h00; drv_en = 1'b1;
        @(negedge clk_50MHz);
        total++; if (data !== 8'h00) begin bad++; $display("FAIL bus_release: got %h want 00", data); end
        drv_en = 1'b0;
        tick(2);
        for (int k = 0; k < 4; k++) begin
            v = 8'($urandom_range(0, 255));
            rx_good_frame(v, "rx_rand");
            if (k % 2 == 1) begin
                cpu_read(got);
                total++; if (got !== exp_hold) begin bad++; $display("FAIL rx_rand_read %0d: got %h want %h", k, got, exp_hold); end
                exp_dr = 1'b0;
                tick(1);
                @(negedge clk_50MHz);
                total++; if (bus.data_ready !== exp_dr) begin bad++; $display("FAIL rx_rand_clear %0d: got %b want %b", k, bus.data_ready, exp_dr); end
                tick(1);
            end
        end
    endtask

    task automatic test_glitch_framing();
        int e0;
        logic [7:0] x;
        logic [7:0] got;
        e0 = err_cnt;
        rxd = 1'b0;
        tick(4);
        rxd = 1'b1;
        tick(3 * C);
        @(negedge clk_50MHz);
        total++; if (bus.data_ready !== exp_dr) begin bad++; $display("FAIL glitch_dr: got %b want %b", bus.data_ready, exp_dr); end
        total++; if (err_cnt - e0 !== 0) begin bad++; $display("FAIL glitch_err: got %0d want 0", err_cnt - e0); end
        tick(1);
        x = 8'($urandom_range(1, 254));
        rx_good_frame(x, "pre_bad");
        e0 = err_cnt;
        rx_bits(8'h55);
        rxd = 1'b0;
        tick(C);
        rxd = 1'b1;
        tick(C);
        @(negedge clk_50MHz);
        total++; if (err_cnt - e0 !== 1) begin bad++; $display("FAIL frame_err_pulse: got %0d want 1", err_cnt - e0); end
        total++; if (bus.data_ready !== exp_dr) begin bad++; $display("FAIL frame_err_dr: got %b want %b", bus.data_ready, exp_dr); end
        tick(1);
        cpu_read(got);
        total++; if (got !== exp_hold) begin bad++; $display("FAIL frame_err_hold: got %h want %h", got, exp_hold); end
        exp_dr = 1'b0;
        tick(3);
    endtask

    task automatic test_reset_abort(input logic [7:0] v);
        logic stayed_high;
        int n;
        cpu_write(v);
        n = 0;
        @(negedge clk_50MHz);
        while (txd !== 1'b0 && n < 10) begin
            @(negedge clk_50MHz);
            n++;
        end
        total++; if (txd !== 1'b0) begin bad++; $display("FAIL abort_start: got %b want 0", txd); end
        repeat (3 * C + 2) @(negedge clk_50MHz);
        @(posedge clk_50MHz);
        #1;
        rst = 1'b0;
        tick(1);
        rst = 1'b1;
        @(negedge clk_50MHz);
        total++; if (txd !== 1'b1) begin bad++; $display("FAIL abort_txd: got %b want 1", txd); end
        total++; if (bus.tsre !== 1'b1) begin bad++; $display("FAIL abort_tsre: got %b want 1", bus.tsre); end
        total++; if (bus.tbre !== 1'b1) begin bad++; $display("FAIL abort_tbre: got %b want 1", bus.tbre); end
        stayed_high = 1'b1;
        for (int i = 0; i < 12 * C; i++) begin
            @(negedge clk_50MHz);
            if (txd !== 1'b1) stayed_high = 1'b0;
        end
        total++; if (stayed_high !== 1'b1) begin bad++; $display("FAIL abort_no_resume: got %b want 1", stayed_high); end
    endtask

    initial begin
        test_reset();
        test_tx_single(8'hA5);
        test_tx_single(8'($urandom_range(0, 255)));
        test_back_to_back(8'h11, 8'h22, 8'h33);
        test_back_to_back(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
        test_rx();
        test_glitch_framing();
        test_reset_abort(8'($urandom_range(0, 255)) | 8'h04);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
